serial_adder: RTL and testbench

- Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
- Each bit is computed by a full-adder cell built from two half adders (XOR/AND) plus an OR, with the carry held in a flip-flop between cycles.
- Sits in the arithmetic path as the sequential consumer of the half-adder cell; trades area for latency.
- Start/busy/done handshake toward the controlling logic.

---
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// with the carry held in a flop between bits and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit pair added per edge (busy)
// DONE  | one-cycle done pulse; start here begins the next add back-to-back
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg_a;
  logic [WIDTH-1:0] shreg_b;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             ha1_s, ha1_c, ha2_c;
  logic             s, carry_next, last;
  logic [WIDTH-1:0] acc_next;

  // Full adder from two half adders plus an OR.
  always_comb begin
    ha1_s      = shreg_a[0] ^ shreg_b[0];
    ha1_c      = shreg_a[0] & shreg_b[0];
    s          = ha1_s ^ carry;
    ha2_c      = ha1_s & carry;
    carry_next = ha1_c | ha2_c;
    acc_next   = {s, acc};
    last       = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg_a <= '0;
      shreg_b <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shreg_a <= a;
            shreg_b <= b;
            carry   <= cin;
            acc     <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          carry   <= carry_next;
          shreg_a <= shreg_a >> 1;
          shreg_b <= shreg_b >> 1;
          acc     <= acc_next[WIDTH-1:1];
          cnt     <= cnt + CW'(1);
          if (last) begin
            sum_q  <= acc_next;
            cout_q <= carry_next;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8): handshake timing,
// results, overflow, ignored start, back-to-back and async reset.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called just after an edge; drives start for one edge (E0), returns #1 after E0.
  task automatic do_start(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges waited until done is seen (#1 after an edge); -1 on timeout.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: busy=%b done=%b sum=%h cout=%b, need all 0", i, busy, done, sum, cout);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: busy=%b done=%b sum=%h cout=%b, need all 0", i, busy, done, sum, cout);
      end
    end
  endtask

  task automatic test_basic;
    int edges, bc;
    do_start(8'h35, 8'h0A, 1'b0);
    a = 8'h00; b = 8'h00;
    wait_done(edges, bc);
    checks++;
    if (edges + 1 !== 9) begin
      failures++;
      $display("FAIL basic_latency: done at edge %0d after start, need 9", edges + 1);
    end
    checks++;
    if (bc !== 8) begin
      failures++;
      $display("FAIL basic_busy: busy for %0d cycles, need 8", bc);
    end
    checks++;
    if (sum !== 8'h3F || cout !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: sum=%h cout=%b, need 3f/0", sum, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h3F) begin
      failures++;
      $display("FAIL basic_after: done=%b busy=%b sum=%h, need 0/0/3f", done, busy, sum);
    end
  endtask

  task automatic test_overflow;
    int edges, bc;
    do_start(8'hFF, 8'h01, 1'b1);
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || sum !== 8'h01 || cout !== 1'b1) begin
      failures++;
      $display("FAIL ovf_cin: edges=%0d sum=%h cout=%b, need 01/1", edges, sum, cout);
    end
    @(posedge clk); #1;
    do_start(8'h80, 8'h80, 1'b0);
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || sum !== 8'h00 || cout !== 1'b1) begin
      failures++;
      $display("FAIL ovf_msb: edges=%0d sum=%h cout=%b, need 00/1", edges, sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_busy;
    int edges, bc, extra;
    do_start(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    a = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || edges + 4 !== 9) begin
      failures++;
      $display("FAIL busy_start_latency: done at edge %0d after start, need 9", edges + 4);
    end
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_result: sum=%h cout=%b, need 30/0", sum, cout);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0 || sum !== 8'h30) begin
      failures++;
      $display("FAIL busy_start_no_second: active cycles=%0d sum=%h, need 0/30", extra, sum);
    end
  endtask

  task automatic test_back_to_back;
    int edges, bc;
    a = 8'h01; b = 8'h02; cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'h7F; b = 8'h01;
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || sum !== 8'h03 || cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: edges=%0d sum=%h cout=%b, need 03/0", edges, sum, cout);
    end
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    checks++;
    if (busy !== 1'b1 || sum !== 8'h03) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b sum=%h, need 1/03", busy, sum);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sum !== 8'h03) begin
      failures++;
      $display("FAIL b2b_hold: sum=%h, need 03", sum);
    end
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || edges + 3 !== 9) begin
      failures++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, need 9", edges + 3);
    end
    checks++;
    if (sum !== 8'h80 || cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: sum=%h cout=%b, need 80/0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int edges, bc, seen;
    do_start(8'hF0, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== 8'h00 || done !== 1'b0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: busy=%b done=%b sum=%h cout=%b, need 0/0/00/0", busy, done, sum, cout);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL async_rst_no_done: active cycles=%0d, need 0", seen);
    end
    do_start(8'h02, 8'h03, 1'b0);
    wait_done(edges, bc);
    checks++;
    if (edges < 0 || sum !== 8'h05 || cout !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_recover: edges=%0d sum=%h cout=%b, need 05/0", edges, sum, cout);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_busy();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
